// File: rtl/u_butterfly_decode_pkg.sv
// Shared unary-datapath types: butterfly lane bundle and the decode-stage FSM encoding.
`timescale 1ns/1ps
package u_butterfly_decode_pkg;

  // Bipolar output bitstreams of one unary butterfly.
  typedef struct packed {
    logic real0;
    logic img0;
    logic real1;
    logic img1;
  } bfly_lanes_t;

  // Decode-stage phases; oBusy covers ST_SKIP and ST_RUN.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SKIP = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } decode_state_e;

  localparam int SKIP_CNT_W = 4;

endpackage

// File: rtl/u_butterfly_decode_stream_count.sv
// Per-lane ones counter for one bipolar stream, with offset removal, gain shift and saturation
// into a registered signed result.
`timescale 1ns/1ps
module u_stream_count
  import u_butterfly_decode_pkg::*;
#(
  parameter int BITWIDTH   = 8,
  parameter int HALF       = 128,
  parameter int GAIN_SHIFT = 2
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iCntClr,
  input  logic                iSample,
  input  logic                iBit,
  input  logic                iLoad,
  input  logic                iZero,
  output logic [BITWIDTH-1:0] oResult
);

  // Headroom: raw spans [-N/2, N/2] and the shift may add GAIN_SHIFT more bits.
  localparam int VW = BITWIDTH + 2 + GAIN_SHIFT;
  localparam logic signed [VW-1:0] HALF_V  = VW'(HALF);
  localparam logic signed [VW-1:0] SAT_MAX = VW'((1 << (BITWIDTH - 1)) - 1);
  localparam logic signed [VW-1:0] SAT_MIN = ~SAT_MAX;

  logic [BITWIDTH:0]      ones_q, ones_d;
  logic [BITWIDTH-1:0]    result_q, result_d;
  logic signed [VW-1:0]   raw_s, shifted_s;
  logic [BITWIDTH-1:0]    sat_s;

  // Decode and next-state for the counter and result register.
  always_comb begin
    raw_s     = $signed({{(VW-BITWIDTH-1){1'b0}}, ones_q}) - HALF_V;
    shifted_s = raw_s <<< GAIN_SHIFT;
    if (shifted_s > SAT_MAX) begin
      sat_s = SAT_MAX[BITWIDTH-1:0];
    end else if (shifted_s < SAT_MIN) begin
      sat_s = SAT_MIN[BITWIDTH-1:0];
    end else begin
      sat_s = shifted_s[BITWIDTH-1:0];
    end

    ones_d   = ones_q;
    result_d = result_q;
    if (iZero) begin
      ones_d   = '0;
      result_d = '0;
    end else if (iCntClr) begin
      ones_d = '0;
    end else if (iSample) begin
      ones_d = ones_q + {{BITWIDTH{1'b0}}, iBit};
    end else if (iLoad) begin
      result_d = sat_s;
    end else begin
      ones_d = ones_q;
    end
  end

  // Counter and result registers.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      ones_q   <= '0;
      result_q <= '0;
    end else begin
      ones_q   <= ones_d;
      result_q <= result_d;
    end
  end

  assign oResult = result_q;

endmodule

// File: rtl/u_butterfly_decode.sv
// Integrates the four butterfly output bitstreams over one N-cycle window and hands the
// signed, gain-restored results downstream over valid/ready.
`timescale 1ns/1ps
module u_butterfly_decode
  import u_butterfly_decode_pkg::*;
#(
  parameter int BITWIDTH   = 8,
  parameter int SKIP       = 3,
  parameter int GAIN_SHIFT = 2
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iClr,
  input  logic                iStart,
  input  logic                iReal0,
  input  logic                iImg0,
  input  logic                iReal1,
  input  logic                iImg1,
  input  logic                iReady,
  output logic                oBusy,
  output logic                oValid,
  output logic [BITWIDTH-1:0] oReal0,
  output logic [BITWIDTH-1:0] oImg0,
  output logic [BITWIDTH-1:0] oReal1,
  output logic [BITWIDTH-1:0] oImg1
);

  localparam int N    = 1 << BITWIDTH;
  localparam int HALF = N >> 1;
  localparam logic [SKIP_CNT_W-1:0] SKIP_LAST = SKIP_CNT_W'((SKIP > 0) ? (SKIP - 1) : 0);
  localparam logic [BITWIDTH-1:0]   RUN_LAST  = BITWIDTH'(N - 1);

  decode_state_e           state_q, state_d;
  logic [SKIP_CNT_W-1:0]   skip_q, skip_d;
  logic [BITWIDTH-1:0]     run_q, run_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic                    cnt_clr_s, sample_s, load_s, zero_s;
  bfly_lanes_t             lanes_s;
  logic [3:0]              lane_bits_s;
  logic [BITWIDTH-1:0]     res_s [4];

  assign lanes_s.real0 = iReal0;
  assign lanes_s.img0  = iImg0;
  assign lanes_s.real1 = iReal1;
  assign lanes_s.img1  = iImg1;
  assign lane_bits_s   = {lanes_s.img1, lanes_s.real1, lanes_s.img0, lanes_s.real0};

  // Window sequencing and handshake.
  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    run_d     = run_q;
    valid_d   = valid_q;
    cnt_clr_s = 1'b0;
    sample_s  = 1'b0;
    load_s    = 1'b0;
    zero_s    = 1'b0;

    if (iClr) begin
      state_d = ST_IDLE;
      skip_d  = '0;
      run_d   = '0;
      valid_d = 1'b0;
      zero_s  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (iStart) begin
            cnt_clr_s = 1'b1;
            skip_d    = '0;
            run_d     = '0;
            state_d   = (SKIP == 0) ? ST_RUN : ST_SKIP;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SKIP: begin
          if (skip_q == SKIP_LAST) begin
            skip_d  = '0;
            state_d = ST_RUN;
          end else begin
            skip_d = skip_q + 4'd1;
          end
        end
        ST_RUN: begin
          sample_s = 1'b1;
          if (run_q == RUN_LAST) begin
            run_d   = '0;
            state_d = ST_DONE;
          end else begin
            run_d = run_q + {{(BITWIDTH-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          // First DONE cycle latches the final counts into the result registers.
          if (!valid_q) begin
            load_s  = 1'b1;
            valid_d = 1'b1;
          end else if (iReady) begin
            valid_d = 1'b0;
            if (iStart) begin
              cnt_clr_s = 1'b1;
              skip_d    = '0;
              run_d     = '0;
              state_d   = (SKIP == 0) ? ST_RUN : ST_SKIP;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            valid_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d == ST_SKIP) || (state_d == ST_RUN);
  end

  // FSM state, window counters and registered status outputs.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= ST_IDLE;
      skip_q  <= '0;
      run_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      run_q   <= run_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    u_stream_count #(
      .BITWIDTH  (BITWIDTH),
      .HALF      (HALF),
      .GAIN_SHIFT(GAIN_SHIFT)
    ) u_cnt (
      .iClk   (iClk),
      .iRstN  (iRstN),
      .iCntClr(cnt_clr_s),
      .iSample(sample_s),
      .iBit   (lane_bits_s[g]),
      .iLoad  (load_s),
      .iZero  (zero_s),
      .oResult(res_s[g])
    );
  end

  assign oBusy  = busy_q;
  assign oValid = valid_q;
  assign oReal0 = res_s[0];
  assign oImg0  = res_s[1];
  assign oReal1 = res_s[2];
  assign oImg1  = res_s[3];

endmodule

// File: tb/tb_u_butterfly_decode.sv
// Directed bench: two SKIP=3 decoders (gain shift 0 and 2) sharing stimulus, plus a SKIP=0 decoder.
`timescale 1ns/1ps
module tb_u_butterfly_decode;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, clr, start, ready;
  logic [3:0] lanes;
  logic       s_clr, s_start, s_ready;
  logic [3:0] s_lanes;

  logic       g0_busy, g0_valid, g2_busy, g2_valid, s_busy, s_valid;
  logic [7:0] g0_out [4];
  logic [7:0] g2_out [4];
  logic [7:0] s_out  [4];

  int n_cmp = 0;
  int n_err = 0;

  u_butterfly_decode #(.BITWIDTH(8), .SKIP(3), .GAIN_SHIFT(0)) dut_g0 (
    .iClk(clk), .iRstN(rst_n), .iClr(clr), .iStart(start),
    .iReal0(lanes[0]), .iImg0(lanes[1]), .iReal1(lanes[2]), .iImg1(lanes[3]),
    .iReady(ready), .oBusy(g0_busy), .oValid(g0_valid),
    .oReal0(g0_out[0]), .oImg0(g0_out[1]), .oReal1(g0_out[2]), .oImg1(g0_out[3]));

  u_butterfly_decode #(.BITWIDTH(8), .SKIP(3), .GAIN_SHIFT(2)) dut_g2 (
    .iClk(clk), .iRstN(rst_n), .iClr(clr), .iStart(start),
    .iReal0(lanes[0]), .iImg0(lanes[1]), .iReal1(lanes[2]), .iImg1(lanes[3]),
    .iReady(ready), .oBusy(g2_busy), .oValid(g2_valid),
    .oReal0(g2_out[0]), .oImg0(g2_out[1]), .oReal1(g2_out[2]), .oImg1(g2_out[3]));

  u_butterfly_decode #(.BITWIDTH(8), .SKIP(0), .GAIN_SHIFT(0)) dut_s0 (
    .iClk(clk), .iRstN(rst_n), .iClr(s_clr), .iStart(s_start),
    .iReal0(s_lanes[0]), .iImg0(s_lanes[1]), .iReal1(s_lanes[2]), .iImg1(s_lanes[3]),
    .iReady(s_ready), .oBusy(s_busy), .oValid(s_valid),
    .oReal0(s_out[0]), .oImg0(s_out[1]), .oReal1(s_out[2]), .oImg1(s_out[3]));

  typedef struct packed {
    logic [3:0][31:0] ones;
    logic [3:0][31:0] e0;
    logic [3:0][31:0] e2;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add_vec(input int o0, o1, o2, o3, a0, a1, a2, a3, b0, b1, b2, b3);
    vec_t v;
    v.ones[0] = o0; v.ones[1] = o1; v.ones[2] = o2; v.ones[3] = o3;
    v.e0[0] = a0; v.e0[1] = a1; v.e0[2] = a2; v.e0[3] = a3;
    v.e2[0] = b0; v.e2[1] = b1; v.e2[2] = b2; v.e2[3] = b3;
    vecs.push_back(v);
  endtask

  // Spreads exactly k ones evenly over 256 samples (k=128 alternates 0/1).
  function automatic logic bres(input int k, input int i);
    return (((i + 1) * k) / 256) != ((i * k) / 256);
  endfunction

  task automatic start_window(input logic with_ready);
    start = 1'b1;
    ready = with_ready;
    @(posedge clk); #1;
    start = 1'b0;
    ready = 1'b0;
  endtask

  // Drives nskip flush cycles of skipbit, then nrun RUN samples; optional stray iStart at sample pulse_at.
  task automatic feed(input int k0, k1, k2, k3, input logic skipbit, input int nskip,
                      input int nrun, input int pulse_at);
    for (int s = 0; s < nskip; s++) begin
      lanes = {4{skipbit}};
      @(posedge clk); #1;
    end
    for (int i = 0; i < nrun; i++) begin
      lanes = {bres(k3, i), bres(k2, i), bres(k1, i), bres(k0, i)};
      start = (i == pulse_at);
      @(posedge clk); #1;
    end
    lanes = 4'b0000;
    start = 1'b0;
  endtask

  task automatic check_all(input string tag, input int a0, a1, a2, a3, b0, b1, b2, b3);
    int ea [4];
    int eb [4];
    ea = '{a0, a1, a2, a3};
    eb = '{b0, b1, b2, b3};
    for (int j = 0; j < 4; j++) begin
      check($sformatf("%s_g0_lane%0d", tag, j), int'($signed(g0_out[j])), ea[j]);
      check($sformatf("%s_g2_lane%0d", tag, j), int'($signed(g2_out[j])), eb[j]);
    end
    check({tag, "_valid"}, int'(g0_valid & g2_valid), 1);
  endtask

  task automatic transfer(input string tag);
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    check({tag, "_xfer_valid"}, int'(g0_valid | g2_valid), 0);
    check({tag, "_xfer_busy"}, int'(g0_busy | g2_busy), 0);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; start = 1'b0; ready = 1'b0; lanes = 4'b0000;
    s_clr = 1'b0; s_start = 1'b0; s_ready = 1'b0; s_lanes = 4'b0000;

    //            ones                 gain 0                 gain 2
    add_vec(256, 0, 128, 0,     127, -128, 0, -128,    127, -128, 0, -128);
    add_vec(136, 160, 96, 120,  8, 32, -32, -8,        32, 127, -128, -32);
    add_vec(129, 127, 130, 200, 1, -1, 2, 72,          4, -4, 8, 127);
    add_vec(159, 97, 140, 108,  31, -31, 12, -20,      124, -124, 48, -80);

    #23;
    check("rst_busy", int'(g0_busy | g2_busy | s_busy), 0);
    check("rst_valid", int'(g0_valid | g2_valid | s_valid), 0);
    check("rst_out", int'(g0_out[0] | g2_out[3] | s_out[1]), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      start_window(1'b0);
      check($sformatf("v%0d_busy", i), int'(g0_busy & g2_busy), 1);
      feed(vecs[i].ones[0], vecs[i].ones[1], vecs[i].ones[2], vecs[i].ones[3],
           1'b0, 3, 256, (i == 1) ? 50 : -1);
      check($sformatf("v%0d_early_valid", i), int'(g0_valid | g2_valid), 0);
      @(posedge clk); #1;
      check_all($sformatf("v%0d", i),
                int'(vecs[i].e0[0]), int'(vecs[i].e0[1]), int'(vecs[i].e0[2]), int'(vecs[i].e0[3]),
                int'(vecs[i].e2[0]), int'(vecs[i].e2[1]), int'(vecs[i].e2[2]), int'(vecs[i].e2[3]));
      check($sformatf("v%0d_busy_done", i), int'(g0_busy | g2_busy), 0);
      if (i == vecs.size() - 1) begin
        for (int c = 0; c < 20; c++) begin
          @(posedge clk); #1;
          check($sformatf("bp%0d_valid", c), int'(g0_valid & g2_valid), 1);
          check($sformatf("bp%0d_g2_real0", c), int'($signed(g2_out[0])), 124);
        end
      end
      transfer($sformatf("v%0d", i));
      check($sformatf("v%0d_hold_out", i), int'($signed(g2_out[1])), int'(vecs[i].e2[1]));
    end

    // Back-to-back windows: second start coincides with the transfer edge.
    start_window(1'b0);
    feed(200, 200, 200, 200, 1'b0, 3, 256, -1);
    @(posedge clk); #1;
    check_all("b2b_a", 72, 72, 72, 72, 127, 127, 127, 127);
    start_window(1'b1);
    check("b2b_valid_drop", int'(g0_valid | g2_valid), 0);
    check("b2b_busy", int'(g0_busy & g2_busy), 1);
    feed(56, 56, 56, 56, 1'b0, 3, 256, -1);
    @(posedge clk); #1;
    check_all("b2b_b", -72, -72, -72, -72, -128, -128, -128, -128);
    transfer("b2b_b");

    // Synchronous abort mid-RUN, then a clean window.
    start_window(1'b0);
    feed(256, 256, 256, 256, 1'b0, 3, 100, -1);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("clr_busy", int'(g0_busy | g2_busy), 0);
    check("clr_valid", int'(g0_valid | g2_valid), 0);
    check("clr_out", int'(g0_out[0] | g0_out[3] | g2_out[0]), 0);
    repeat (5) @(posedge clk);
    #1;
    check("clr_no_valid", int'(g0_valid | g2_valid), 0);
    start_window(1'b0);
    feed(128, 128, 128, 128, 1'b0, 3, 256, -1);
    @(posedge clk); #1;
    check_all("clr_restart", 0, 0, 0, 0, 0, 0, 0, 0);
    transfer("clr_restart");

    // Asynchronous reset pulse mid-RUN, then a clean window.
    start_window(1'b0);
    feed(256, 256, 256, 256, 1'b0, 3, 100, -1);
    check("rstp_busy_before", int'(g0_busy & g2_busy), 1);
    #2 rst_n = 1'b0;
    #1 check("rstp_busy", int'(g0_busy | g2_busy), 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rstp_valid", int'(g0_valid | g2_valid), 0);
    start_window(1'b0);
    feed(128, 128, 128, 128, 1'b0, 3, 256, -1);
    @(posedge clk); #1;
    check_all("rstp_restart", 0, 0, 0, 0, 0, 0, 0, 0);
    transfer("rstp_restart");

    // Ones driven only during the flush cycles must not be counted.
    start_window(1'b0);
    feed(0, 0, 0, 0, 1'b1, 3, 256, -1);
    @(posedge clk); #1;
    check_all("skip3", -128, -128, -128, -128, -128, -128, -128, -128);
    transfer("skip3");

    // SKIP=0: the very first bit after iStart is sampled; valid at t0+N+1.
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    check("s0_busy", int'(s_busy), 1);
    for (int i = 0; i < 256; i++) begin
      s_lanes = {bres(128, i), 1'b1, 1'b0, (i == 0)};
      @(posedge clk); #1;
    end
    s_lanes = 4'b0000;
    check("s0_early_valid", int'(s_valid), 0);
    @(posedge clk); #1;
    check("s0_valid", int'(s_valid), 1);
    check("s0_real0", int'($signed(s_out[0])), -127);
    check("s0_img0", int'($signed(s_out[1])), -128);
    check("s0_real1", int'($signed(s_out[2])), 127);
    check("s0_img1", int'($signed(s_out[3])), 0);
    s_ready = 1'b1;
    @(posedge clk); #1;
    s_ready = 1'b0;
    check("s0_xfer_valid", int'(s_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
